// File: rtl/bit_enum_encoder.sv
// Sequential bit enumerator: accepts a WIDTH-bit vector and emits one index per set bit.
// Optional count_o (popcount of the accepted vector) when BIT_ENUM_ENCODER_COUNT_EN is defined.
//
// state | meaning
// IDLE  | ready_o=1, waiting for a request vector
// SCAN  | valid_o=1, emitting one index per beat from the mask register
module bit_enum_encoder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int Q_W       = $clog2(WIDTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [Q_W-1:0]               q_o,
  output logic                         none_o,
  output logic                         last_o,
  output logic                         valid_o,
`ifdef BIT_ENUM_ENCODER_COUNT_EN
  output logic [$clog2(WIDTH+1)-1:0]   count_o,
`endif
  input  logic                         ready_i
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [Q_W-1:0]   sel_idx;
  logic             accept;
  logic             beat_done;

  assign ready_o   = rst_n_i && (state_q == IDLE);
  assign accept    = valid_i && ready_o;
  assign beat_done = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SCAN;
          mask_d  = data_i;
        end
      end
      SCAN: begin
        if (beat_done) begin
          if (last_o) begin
            state_d = IDLE;
            mask_d  = '0;
          end else begin
            mask_d[q_o] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select from the next mask so the output registers already hold the upcoming beat.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST != 0) begin
        if (mask_d[i]) sel_idx = Q_W'(i);
      end else begin
        if (mask_d[WIDTH-1-i]) sel_idx = Q_W'(WIDTH-1-i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      valid_o <= 1'b0;
      q_o     <= '0;
      none_o  <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      valid_o <= (state_d == SCAN);
      if (state_d == SCAN) begin
        q_o    <= sel_idx;
        none_o <= (mask_d == '0);
        last_o <= ((mask_d & (mask_d - WIDTH'(1))) == '0);
      end else begin
        q_o    <= '0;
        none_o <= 1'b0;
        last_o <= 1'b0;
      end
    end
  end

`ifdef BIT_ENUM_ENCODER_COUNT_EN
  localparam int CNT_W = $clog2(WIDTH+1);

  logic [CNT_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) pop = pop + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_o <= '0;
    else if (accept) count_o <= pop;
  end
`endif

endmodule

// File: tb/tb_bit_enum_encoder.sv
// Bench for bit_enum_encoder: LSB-first and MSB-first 8-bit instances in lockstep,
// plus a 16-bit LSB-first instance; expected beats come from a set-bit list model.
module tb_bit_enum_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d8;
  logic       v8, r8;
  logic       ready_a, none_a, last_a, valid_a;
  logic [2:0] q_a;
  logic       ready_b, none_b, last_b, valid_b;
  logic [2:0] q_b;
  logic [15:0] d16;
  logic        v16, r16;
  logic        ready_c, none_c, last_c, valid_c;
  logic [3:0]  q_c;
`ifdef BIT_ENUM_ENCODER_COUNT_EN
  logic [3:0] cnt_a, cnt_b;
  logic [4:0] cnt_c;
`endif

  int tests = 0;
  int fails = 0;

  bit_enum_encoder #(.WIDTH(8), .MSB_FIRST(0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d8), .valid_i(v8), .ready_o(ready_a),
    .q_o(q_a), .none_o(none_a), .last_o(last_a), .valid_o(valid_a),
`ifdef BIT_ENUM_ENCODER_COUNT_EN
    .count_o(cnt_a),
`endif
    .ready_i(r8));

  bit_enum_encoder #(.WIDTH(8), .MSB_FIRST(1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d8), .valid_i(v8), .ready_o(ready_b),
    .q_o(q_b), .none_o(none_b), .last_o(last_b), .valid_o(valid_b),
`ifdef BIT_ENUM_ENCODER_COUNT_EN
    .count_o(cnt_b),
`endif
    .ready_i(r8));

  bit_enum_encoder #(.WIDTH(16), .MSB_FIRST(0)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d16), .valid_i(v16), .ready_o(ready_c),
    .q_o(q_c), .none_o(none_c), .last_o(last_c), .valid_o(valid_c),
`ifdef BIT_ENUM_ENCODER_COUNT_EN
    .count_o(cnt_c),
`endif
    .ready_i(r16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  // stall bit k forces ready_i low on scan cycle k; abort_at pulses reset before that beat
  task automatic send8(input logic [7:0] vec, input logic [31:0] stall, input bit rnd,
                       input int abort_at);
    int ea[$];
    int eb[$];
    int idx, guard, n;
    guard = 0;
    while (!ready_a && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_a_before", 32'(ready_a), 1);
    chk("ready_b_before", 32'(ready_b), 1);
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) begin
        ea.push_back(i);
        eb.push_front(i);
      end
    end
    if (ea.size() == 0) begin
      ea.push_back(0);
      eb.push_back(0);
    end
    n = ea.size();
    d8 = vec;
    v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    d8 = 8'($urandom);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 100) begin
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid_a", 32'(valid_a), 0);
        chk("abort_valid_b", 32'(valid_b), 0);
        chk("abort_ready_a", 32'(ready_a), 0);
        r8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready_a", 32'(ready_a), 1);
        chk("post_rst_valid_a", 32'(valid_a), 0);
`ifdef BIT_ENUM_ENCODER_COUNT_EN
        chk("post_rst_count_a", 32'(cnt_a), 0);
`endif
        return;
      end
      chk("valid_a", 32'(valid_a), 1);
      chk("valid_b", 32'(valid_b), 1);
      chk("q_a", 32'(q_a), 32'(ea[idx]));
      chk("q_b", 32'(q_b), 32'(eb[idx]));
      chk("last_a", 32'(last_a), 32'(idx == n - 1));
      chk("last_b", 32'(last_b), 32'(idx == n - 1));
      chk("none_a", 32'(none_a), 32'(vec == 8'h00));
      chk("none_b", 32'(none_b), 32'(vec == 8'h00));
      chk("ready_a_scan", 32'(ready_a), 0);
`ifdef BIT_ENUM_ENCODER_COUNT_EN
      chk("count_a", 32'(cnt_a), 32'(popc({8'h00, vec})));
      chk("count_b", 32'(cnt_b), 32'(popc({8'h00, vec})));
`endif
      if (rnd) r8 = ($urandom_range(0, 2) != 0);
      else r8 = (guard < 32) ? !stall[guard] : 1'b1;
      @(negedge clk);
      if (r8) idx++;
      guard++;
    end
    r8 = 1'b0;
    chk("beats_a", 32'(idx), 32'(n));
    chk("end_valid_a", 32'(valid_a), 0);
    chk("end_valid_b", 32'(valid_b), 0);
    chk("end_ready_a", 32'(ready_a), 1);
  endtask

  task automatic send16(input logic [15:0] vec);
    int ec[$];
    int idx, guard, n;
    for (int i = 0; i < 16; i++) if (vec[i]) ec.push_back(i);
    if (ec.size() == 0) ec.push_back(0);
    n = ec.size();
    chk("ready_c_before", 32'(ready_c), 1);
    d16 = vec;
    v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 100) begin
      chk("valid_c", 32'(valid_c), 1);
      chk("q_c", 32'(q_c), 32'(ec[idx]));
      chk("last_c", 32'(last_c), 32'(idx == n - 1));
      chk("none_c", 32'(none_c), 32'(vec == 16'h0000));
`ifdef BIT_ENUM_ENCODER_COUNT_EN
      chk("count_c", 32'(cnt_c), 32'(popc(vec)));
`endif
      r16 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (r16) idx++;
      guard++;
    end
    r16 = 1'b0;
    chk("beats_c", 32'(idx), 32'(n));
    chk("end_valid_c", 32'(valid_c), 0);
    chk("end_ready_c", 32'(ready_c), 1);
  endtask

  initial begin
    logic [7:0]  rv8;
    logic [15:0] rv16;
    rst_n = 1'b0;
    d8 = '0; v8 = 1'b0; r8 = 1'b0;
    d16 = '0; v16 = 1'b0; r16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid_a", 32'(valid_a), 0);
    chk("rst_ready_a", 32'(ready_a), 0);
    chk("rst_q_a", 32'(q_a), 0);
    chk("rst_none_a", 32'(none_a), 0);
    chk("rst_last_a", 32'(last_a), 0);
    chk("rst_valid_c", 32'(valid_c), 0);
`ifdef BIT_ENUM_ENCODER_COUNT_EN
    chk("rst_count_a", 32'(cnt_a), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_a", 32'(ready_a), 1);

    send8(8'hA2, 32'h0, 1'b0, -1);
    send8(8'h00, 32'h0, 1'b0, -1);
    send8(8'h12, 32'h7, 1'b0, -1);
    send8(8'hFF, 32'h0, 1'b0, 3);
    send8(8'h80, 32'h0, 1'b0, -1);
    for (int k = 0; k < 20; k++) begin
      rv8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      send8(rv8, 32'h0, 1'b1, -1);
    end

    send16(16'h8001);
    for (int k = 0; k < 6; k++) begin
      rv16 = 16'($urandom);
      send16(rv16);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
